// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers dispatched ops until both operands are
// resolved by CDB broadcast, then issues the lowest-index ready op through a registered stage.
module alu_rs #(
    parameter int RS_SIZE = 16,
    parameter int OP_W    = 6,
    parameter int TAG_W   = 5,
    parameter int XLEN    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  in_op,
    input  logic [XLEN-1:0]  in_V1,
    input  logic [XLEN-1:0]  in_V2,
    input  logic [TAG_W-1:0] in_Q1,
    input  logic [TAG_W-1:0] in_Q2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_rob_id,
    input  logic             alu_cdb_valid,
    input  logic [TAG_W-1:0] alu_cdb_tag,
    input  logic [XLEN-1:0]  alu_cdb_val,
    input  logic             lsb_cdb_valid,
    input  logic [TAG_W-1:0] lsb_cdb_tag,
    input  logic [XLEN-1:0]  lsb_cdb_val,
    output logic             full,
    output logic [OP_W-1:0]  out_op,
    output logic [XLEN-1:0]  out_V1,
    output logic [XLEN-1:0]  out_V2,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_pc,
    output logic [TAG_W-1:0] out_rob_id
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [XLEN-1:0]  v;
        logic [TAG_W-1:0] q;
    } opnd_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        opnd_t            s1;
        opnd_t            s2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [TAG_W-1:0] rob;
    } entry_t;

    // An operand waiting on a tag captures the value from whichever CDB carries that tag.
    function automatic opnd_t resolve(
        input opnd_t             o,
        input logic              a_vld,
        input logic [TAG_W-1:0]  a_tag,
        input logic [XLEN-1:0]   a_val,
        input logic              l_vld,
        input logic [TAG_W-1:0]  l_tag,
        input logic [XLEN-1:0]   l_val
    );
        opnd_t r;
        r = o;
        if (a_vld && a_tag != '0 && o.q == a_tag) begin
            r.v = a_val;
            r.q = '0;
        end else if (l_vld && l_tag != '0 && o.q == l_tag) begin
            r.v = l_val;
            r.q = '0;
        end
        return r;
    endfunction

    logic [RS_SIZE-1:0] busy_q, busy_d;
    entry_t             ent_q [RS_SIZE];
    entry_t             ent_d [RS_SIZE];
    logic [CNT_W-1:0]   count_q, count_d;

    logic [OP_W-1:0]    out_op_q, out_op_d;
    logic [XLEN-1:0]    out_v1_q, out_v1_d;
    logic [XLEN-1:0]    out_v2_q, out_v2_d;
    logic [XLEN-1:0]    out_imm_q, out_imm_d;
    logic [XLEN-1:0]    out_pc_q, out_pc_d;
    logic [TAG_W-1:0]   out_rob_q, out_rob_d;

    logic [RS_SIZE-1:0] ready;
    logic               issue_vld;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W-1:0]   free_idx;
    logic               dispatch;
    opnd_t              disp_s1, disp_s2;

    assign full     = (count_q == CNT_W'(RS_SIZE));
    assign dispatch = in_valid && !full;

    // Priority pick: iterating downward leaves the lowest matching index.
    always_comb begin
        issue_vld = 1'b0;
        issue_idx = '0;
        free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            ready[i] = busy_q[i] && ent_q[i].s1.q == '0 && ent_q[i].s2.q == '0;
            if (ready[i]) begin
                issue_vld = 1'b1;
                issue_idx = i[IDX_W-1:0];
            end
            if (!busy_q[i]) begin
                free_idx = i[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        busy_d  = busy_q;
        ent_d   = ent_q;
        disp_s1 = resolve('{v: in_V1, q: in_Q1}, alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
                          lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val);
        disp_s2 = resolve('{v: in_V2, q: in_Q2}, alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
                          lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val);
        for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i]) begin
                ent_d[i].s1 = resolve(ent_q[i].s1, alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
                                      lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val);
                ent_d[i].s2 = resolve(ent_q[i].s2, alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
                                      lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val);
            end
        end
        if (issue_vld) begin
            busy_d[issue_idx] = 1'b0;
        end
        if (dispatch) begin
            busy_d[free_idx] = 1'b1;
            ent_d[free_idx]  = '{op: in_op, s1: disp_s1, s2: disp_s2,
                                 imm: in_imm, pc: in_pc, rob: in_rob_id};
        end
        count_d = count_q + CNT_W'(dispatch) - CNT_W'(issue_vld);

        out_op_d  = '0;
        out_v1_d  = '0;
        out_v2_d  = '0;
        out_imm_d = '0;
        out_pc_d  = '0;
        out_rob_d = '0;
        if (issue_vld) begin
            out_op_d  = ent_q[issue_idx].op;
            out_v1_d  = ent_q[issue_idx].s1.v;
            out_v2_d  = ent_q[issue_idx].s2.v;
            out_imm_d = ent_q[issue_idx].imm;
            out_pc_d  = ent_q[issue_idx].pc;
            out_rob_d = ent_q[issue_idx].rob;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            count_q   <= '0;
            out_op_q  <= '0;
            out_v1_q  <= '0;
            out_v2_q  <= '0;
            out_imm_q <= '0;
            out_pc_q  <= '0;
            out_rob_q <= '0;
        end else if (rdy) begin
            if (rollback) begin
                busy_q    <= '0;
                count_q   <= '0;
                out_op_q  <= '0;
                out_v1_q  <= '0;
                out_v2_q  <= '0;
                out_imm_q <= '0;
                out_pc_q  <= '0;
                out_rob_q <= '0;
            end else begin
                busy_q    <= busy_d;
                count_q   <= count_d;
                out_op_q  <= out_op_d;
                out_v1_q  <= out_v1_d;
                out_v2_q  <= out_v2_d;
                out_imm_q <= out_imm_d;
                out_pc_q  <= out_pc_d;
                out_rob_q <= out_rob_d;
            end
        end
    end

    // Entry payload is qualified by busy, so it needs no reset.
    always_ff @(posedge clk) begin
        if (rdy) begin
            ent_q <= ent_d;
        end
    end

    assign out_op     = out_op_q;
    assign out_V1     = out_v1_q;
    assign out_V2     = out_v2_q;
    assign out_imm    = out_imm_q;
    assign out_pc     = out_pc_q;
    assign out_rob_id = out_rob_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus random traffic, every cycle checked against a
// behavioural model of the reservation station held as plain arrays.
module tb_alu_rs;

    localparam int N = 16;

    logic        clk, rst, rdy, rollback, in_valid;
    logic [5:0]  in_op;
    logic [31:0] in_V1, in_V2, in_imm, in_pc;
    logic [4:0]  in_Q1, in_Q2, in_rob_id;
    logic        alu_cdb_valid, lsb_cdb_valid;
    logic [4:0]  alu_cdb_tag, lsb_cdb_tag;
    logic [31:0] alu_cdb_val, lsb_cdb_val;
    logic        full;
    logic [5:0]  out_op;
    logic [31:0] out_V1, out_V2, out_imm, out_pc;
    logic [4:0]  out_rob_id;

    alu_rs dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .in_valid(in_valid),
        .in_op(in_op), .in_V1(in_V1), .in_V2(in_V2), .in_Q1(in_Q1), .in_Q2(in_Q2),
        .in_imm(in_imm), .in_pc(in_pc), .in_rob_id(in_rob_id),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_val(lsb_cdb_val),
        .full(full), .out_op(out_op), .out_V1(out_V1), .out_V2(out_V2),
        .out_imm(out_imm), .out_pc(out_pc), .out_rob_id(out_rob_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: one slot per entry, plus occupancy and the expected output register.
    bit          m_busy [N];
    logic [5:0]  m_op   [N];
    logic [31:0] m_v1 [N], m_v2 [N], m_imm [N], m_pc [N];
    logic [4:0]  m_q1 [N], m_q2 [N], m_rob [N];
    int          m_cnt;
    logic [5:0]  e_op;
    logic [31:0] e_v1, e_v2, e_imm, e_pc;
    logic [4:0]  e_rob;
    bit          e_known;

    function automatic bit cdb_hit(input logic [4:0] q, output logic [31:0] v);
        v = '0;
        if (alu_cdb_valid && alu_cdb_tag != 0 && q == alu_cdb_tag) begin
            v = alu_cdb_val;
            return 1'b1;
        end
        if (lsb_cdb_valid && lsb_cdb_tag != 0 && q == lsb_cdb_tag) begin
            v = lsb_cdb_val;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_step();
        int iss, slot;
        logic [31:0] v;
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_cnt = 0;
            {e_op, e_v1, e_v2, e_imm, e_pc, e_rob} = '0;
            e_known = 1;
        end else if (rdy) begin
            if (rollback) begin
                foreach (m_busy[i]) m_busy[i] = 0;
                m_cnt = 0;
                e_op = 0;
                e_rob = 0;
                e_known = 0;
            end else begin
                iss = -1;
                slot = -1;
                for (int i = 0; i < N; i++) begin
                    if (iss < 0 && m_busy[i] && m_q1[i] == 0 && m_q2[i] == 0) iss = i;
                    if (slot < 0 && !m_busy[i]) slot = i;
                end
                e_known = 1;
                if (iss >= 0) begin
                    e_op = m_op[iss]; e_v1 = m_v1[iss]; e_v2 = m_v2[iss];
                    e_imm = m_imm[iss]; e_pc = m_pc[iss]; e_rob = m_rob[iss];
                end else begin
                    {e_op, e_v1, e_v2, e_imm, e_pc, e_rob} = '0;
                end
                for (int i = 0; i < N; i++) begin
                    if (m_busy[i]) begin
                        if (cdb_hit(m_q1[i], v)) begin m_v1[i] = v; m_q1[i] = 0; end
                        if (cdb_hit(m_q2[i], v)) begin m_v2[i] = v; m_q2[i] = 0; end
                    end
                end
                if (iss >= 0) begin
                    m_busy[iss] = 0;
                    m_cnt--;
                end
                if (in_valid && (m_cnt + (iss >= 0 ? 1 : 0)) < N) begin
                    m_busy[slot] = 1;
                    m_op[slot] = in_op; m_imm[slot] = in_imm; m_pc[slot] = in_pc;
                    m_rob[slot] = in_rob_id;
                    m_v1[slot] = in_V1; m_q1[slot] = in_Q1;
                    m_v2[slot] = in_V2; m_q2[slot] = in_Q2;
                    if (cdb_hit(in_Q1, v)) begin m_v1[slot] = v; m_q1[slot] = 0; end
                    if (cdb_hit(in_Q2, v)) begin m_v2[slot] = v; m_q2[slot] = 0; end
                    m_cnt++;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("out_op", {58'd0, out_op}, {58'd0, e_op});
        chk("out_rob_id", {59'd0, out_rob_id}, {59'd0, e_rob});
        chk("full", {63'd0, full}, {63'd0, m_cnt == N});
        if (e_known) begin
            chk("out_V1", {32'd0, out_V1}, {32'd0, e_v1});
            chk("out_V2", {32'd0, out_V2}, {32'd0, e_v2});
            chk("out_imm", {32'd0, out_imm}, {32'd0, e_imm});
            chk("out_pc", {32'd0, out_pc}, {32'd0, e_pc});
        end
    endtask

    task automatic idle();
        rst = 0; rdy = 1; rollback = 0; in_valid = 0;
        alu_cdb_valid = 0; lsb_cdb_valid = 0; alu_cdb_tag = 0; lsb_cdb_tag = 0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] v1, input logic [4:0] q1,
                        input logic [31:0] v2, input logic [4:0] q2, input logic [4:0] rob);
        in_valid = 1; in_op = op; in_V1 = v1; in_Q1 = q1; in_V2 = v2; in_Q2 = q2;
        in_rob_id = rob; in_imm = $urandom; in_pc = $urandom;
    endtask

    initial begin
        idle();
        in_op = 0; in_V1 = 0; in_V2 = 0; in_Q1 = 0; in_Q2 = 0; in_imm = 0; in_pc = 0;
        in_rob_id = 0; alu_cdb_val = 0; lsb_cdb_val = 0;
        m_cnt = 0;
        rst = 1;
        tick();
        chk("reset_op", {58'd0, out_op}, 64'd0);
        chk("reset_full", {63'd0, full}, 64'd0);
        idle();

        // Ready op dispatched: visible one edge later, then NOP.
        disp(6'd1, 32'd5, 5'd0, 32'd7, 5'd0, 5'd3);
        tick();
        chk("t1_not_yet", {58'd0, out_op}, 64'd0);
        idle();
        tick();
        chk("t1_op", {58'd0, out_op}, 64'd1);
        chk("t1_v1", {32'd0, out_V1}, 64'd5);
        chk("t1_v2", {32'd0, out_V2}, 64'd7);
        chk("t1_rob", {59'd0, out_rob_id}, 64'd3);
        tick();
        chk("t1_nop", {58'd0, out_op}, 64'd0);

        // Blocked on tag 4 until the ALU CDB delivers it.
        disp(6'd2, 32'd0, 5'd4, 32'd1, 5'd0, 5'd5);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_wait", {58'd0, out_op}, 64'd0);
        end
        alu_cdb_valid = 1; alu_cdb_tag = 5'd4; alu_cdb_val = 32'd9;
        tick();
        chk("t2_wake_edge", {58'd0, out_op}, 64'd0);
        idle();
        tick();
        chk("t2_op", {58'd0, out_op}, 64'd2);
        chk("t2_v1", {32'd0, out_V1}, 64'd9);

        // Same-cycle forwarding from the LSB CDB at dispatch.
        disp(6'd3, 32'd0, 5'd0, 32'd0, 5'd6, 5'd7);
        lsb_cdb_valid = 1; lsb_cdb_tag = 5'd6; lsb_cdb_val = 32'hdead;
        tick();
        idle();
        tick();
        chk("t3_v2", {32'd0, out_V2}, 64'hdead);
        chk("t3_rob", {59'd0, out_rob_id}, 64'd7);

        // Fill all entries, overflow attempt, then wake entry 5.
        for (int i = 0; i < N; i++) begin
            disp(6'd4, i, 5'(i + 8), 32'd0, 5'd0, 5'(i + 1));
            tick();
        end
        chk("t4_full", {63'd0, full}, 64'd1);
        disp(6'd4, 32'd0, 5'd0, 32'd0, 5'd0, 5'd31);
        tick();
        chk("t4_still_full", {63'd0, full}, 64'd1);
        idle();
        alu_cdb_valid = 1; alu_cdb_tag = 5'd13; alu_cdb_val = 32'd55;
        tick();
        idle();
        tick();
        chk("t4_rob", {59'd0, out_rob_id}, 64'd6);
        chk("t4_v1", {32'd0, out_V1}, 64'd55);
        chk("t4_full_drop", {63'd0, full}, 64'd0);
        rollback = 1;
        tick();
        idle();

        // Entries 2 and 9 wake together: lower index first.
        for (int i = 0; i < 10; i++) begin
            disp(6'd5, 32'd0, 5'(i + 8), 32'd0, 5'd0, 5'(i + 1));
            tick();
        end
        idle();
        alu_cdb_valid = 1; alu_cdb_tag = 5'd10; alu_cdb_val = 32'd1;
        lsb_cdb_valid = 1; lsb_cdb_tag = 5'd17; lsb_cdb_val = 32'd2;
        tick();
        idle();
        tick();
        chk("t5_first", {59'd0, out_rob_id}, 64'd3);
        tick();
        chk("t5_second", {59'd0, out_rob_id}, 64'd10);
        rollback = 1;
        tick();
        idle();

        // Rollback discards pending entries and a same-cycle dispatch.
        for (int i = 0; i < 8; i++) begin
            disp(6'd6, 32'd0, 5'(i + 8), 32'd0, 5'd0, 5'(i + 1));
            tick();
        end
        disp(6'd6, 32'd1, 5'd0, 32'd2, 5'd0, 5'd20);
        rollback = 1;
        tick();
        chk("t6_full", {63'd0, full}, 64'd0);
        chk("t6_op", {58'd0, out_op}, 64'd0);
        idle();
        alu_cdb_valid = 1; alu_cdb_tag = 5'd8; alu_cdb_val = 32'd3;
        lsb_cdb_valid = 1; lsb_cdb_tag = 5'd9; lsb_cdb_val = 32'd4;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_issue", {58'd0, out_op}, 64'd0);
        end
        disp(6'd7, 32'd1, 5'd0, 32'd2, 5'd0, 5'd21);
        tick();
        disp(6'd7, 32'd1, 5'd0, 32'd2, 5'd0, 5'd22);
        tick();
        idle();
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_freeze", {59'd0, out_rob_id}, 64'd21);
        end
        rdy = 1;
        tick();
        chk("t6_resume", {59'd0, out_rob_id}, 64'd22);
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) == 1) begin
                disp(6'($urandom_range(1, 63)), $urandom,
                     ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 7)),
                     $urandom,
                     ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 7)),
                     5'($urandom_range(1, 31)));
            end
            alu_cdb_valid = $urandom_range(0, 1) == 1;
            alu_cdb_tag = 5'($urandom_range(0, 7));
            alu_cdb_val = $urandom;
            lsb_cdb_valid = $urandom_range(0, 1) == 1;
            lsb_cdb_tag = 5'($urandom_range(0, 7));
            lsb_cdb_val = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
